// File: rtl/ee357_mcpu_mem_if.sv
// Memory strobe/bus bundle between the multicycle control unit/datapath and its
// unified memory. The master drives requests; the slave answers with ready/err.
interface ee357_mcpu_mem_if;
  logic        mr;
  logic        mw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output mr, mw, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  mr, mw, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/ee357_mcpu_mem.sv
// Multi-cycle unified instruction/data memory with programmable wait states.
// Define MCPU_MEM_ALIGN_CHK_EN to reject misaligned requests with err.
module ee357_mcpu_mem #(
  parameter int AW       = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  ee357_mcpu_mem_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          op_wr_q, op_wr_d;
  logic          err_q, err_d;
  logic          do_write;
  logic          misalign;
  logic          reject;

  logic [31:0]   mem [2**AW];

  // Upper address bits alias and the byte offset is only inspected by the align check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

`ifdef MCPU_MEM_ALIGN_CHK_EN
  assign misalign = (bus.mr | bus.mw) && (bus.addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign reject = (bus.mr & bus.mw) | misalign;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    op_wr_d  = op_wr_q;
    err_d    = err_q;
    do_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reject) begin
          err_d   = 1'b1;
          state_d = S_ACK;
        end else if (bus.mr ^ bus.mw) begin
          idx_d   = bus.addr[AW+1:2];
          wdata_d = bus.wdata;
          op_wr_d = bus.mw;
          cnt_d   = WAIT_INIT;
          err_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The access itself happens on the edge that enters ACK.
          if (op_wr_q) begin
            do_write = 1'b1;
          end else begin
            rdata_d = mem[idx_q];
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      op_wr_q <= op_wr_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; a reset in WAIT leaves state_q in IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == S_ACK);
  assign bus.busy  = (state_q == S_WAIT);
  assign bus.err   = (state_q == S_ACK) && err_q;

endmodule

// File: tb/tb_ee357_mcpu_mem.sv
// Directed + randomized bench for ee357_mcpu_mem: one DUT with 2 wait states and
// one with 0 wait states, both checked against an array-based reference model.
module tb_ee357_mcpu_mem;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ee357_mcpu_mem_if bus_a ();
  ee357_mcpu_mem_if bus_b ();

  ee357_mcpu_mem #(.AW(AW), .WAIT_CYC(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  ee357_mcpu_mem #(.AW(AW), .WAIT_CYC(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;

  logic [31:0] model   [2][256];
  logic [31:0] rdata_m [2];
  int          waitc   [2] = '{2, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int w, input logic r, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (w == 0) begin
      bus_a.mr = r; bus_a.mw = wr; bus_a.addr = a; bus_a.wdata = d;
    end else begin
      bus_b.mr = r; bus_b.mw = wr; bus_b.addr = a; bus_b.wdata = d;
    end
  endtask

  task automatic get_out(input int w, output logic rdy, output logic bsy,
                         output logic er, output logic [31:0] rd);
    if (w == 0) begin
      rdy = bus_a.ready; bsy = bus_a.busy; er = bus_a.err; rd = bus_a.rdata;
    end else begin
      rdy = bus_b.ready; bsy = bus_b.busy; er = bus_b.err; rd = bus_b.rdata;
    end
  endtask

  // One request held until ready, then dropped during ACK.
  task automatic access(input int w, input logic r, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic        rej;
    int          n;
    int          exp_lat;
    int          idx;
    logic        rdy, bsy, er;
    logic [31:0] rd;
    rej = r && wr;
`ifdef MCPU_MEM_ALIGN_CHK_EN
    if ((r || wr) && (a[1:0] != 2'b00)) rej = 1'b1;
`endif
    idx = int'((a >> 2) % 256);
    @(negedge clk);
    set_req(w, r, wr, a, d);
    @(posedge clk); #1;
    n = 0;
    get_out(w, rdy, bsy, er, rd);
    while (!rdy && n < 40) begin
      chk({tag, "_busy"}, {31'd0, bsy}, 32'd1);
      @(posedge clk); #1;
      n++;
      get_out(w, rdy, bsy, er, rd);
    end
    set_req(w, 1'b0, 1'b0, $urandom, $urandom);
    exp_lat = rej ? 0 : waitc[w] + 1;
    if (!rej) begin
      if (wr) model[w][idx] = d;
      else    rdata_m[w]    = model[w][idx];
    end
    chk({tag, "_ready"}, {31'd0, rdy}, 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_err"}, {31'd0, er}, {31'd0, rej});
    chk({tag, "_busy_ack"}, {31'd0, bsy}, 32'd0);
    chk({tag, "_rdata"}, rd, rdata_m[w]);
    @(posedge clk); #1;
    get_out(w, rdy, bsy, er, rd);
    chk({tag, "_ready_pulse"}, {31'd0, rdy}, 32'd0);
    chk({tag, "_busy_idle"}, {31'd0, bsy}, 32'd0);
    $display("txn %s dut=%0d mr=%0b mw=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
             tag, w, r, wr, a, d, rd, er, n);
  endtask

  task automatic chk_reset(input string tag);
    logic rdy, bsy, er;
    logic [31:0] rd;
    for (int w = 0; w < 2; w++) begin
      get_out(w, rdy, bsy, er, rd);
      chk({tag, "_ready"}, {31'd0, rdy}, 32'd0);
      chk({tag, "_busy"},  {31'd0, bsy}, 32'd0);
      chk({tag, "_err"},   {31'd0, er},  32'd0);
      chk({tag, "_rdata"}, rd, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] tmp;
    logic [31:0] a;
    int          op;
    for (int w = 0; w < 2; w++) begin
      set_req(w, 1'b0, 1'b0, 32'd0, 32'd0);
      rdata_m[w] = 32'd0;
      for (int i = 0; i < 256; i++) model[w][i] = 32'd0;
    end

    // Reset held for three cycles.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    // Give every word the tests touch a known value.
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 16; i++)
        access(w, 1'b0, 1'b1, 32'(i * 4), $urandom, "preload");

    access(0, 1'b1, 1'b0, 32'h10, 32'd0, "read_0x10");
    access(0, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, "write_0x20");
    access(0, 1'b1, 1'b0, 32'h20, 32'd0, "readback_0x20");
    access(0, 1'b1, 1'b1, 32'h20, 32'h0BAD0BAD, "conflict");
    access(0, 1'b1, 1'b0, 32'h20, 32'd0, "after_conflict");

    // Reset lands in cycle 2 of a write; the write must never commit.
    @(negedge clk);
    set_req(0, 1'b0, 1'b1, 32'h30, 32'h12345678);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("reset_midwrite");
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    rdata_m[0] = 32'd0;
    rdata_m[1] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    access(0, 1'b1, 1'b0, 32'h30, 32'd0, "read_0x30_old");

    access(1, 1'b0, 1'b1, 32'h004, 32'hA5A5A5A5, "w0_write_0x004");
    access(1, 1'b1, 1'b0, 32'h404, 32'd0, "w0_read_0x404");
    access(0, 1'b1, 1'b0, 32'h13, 32'd0, "misaligned_0x13");

    for (int k = 0; k < 60; k++) begin
      tmp = $urandom;
      a   = {tmp[31:6], 4'($urandom_range(0, 15)), tmp[1:0]};
      op  = $urandom_range(0, 9);
      if (op == 0)      access(k % 2, 1'b1, 1'b1, a, $urandom, "rnd_conflict");
      else if (op < 5)  access(k % 2, 1'b0, 1'b1, a, $urandom, "rnd_write");
      else              access(k % 2, 1'b1, 1'b0, a, $urandom, "rnd_read");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ee357_mcpu_mem.md
Name: ee357_mcpu_mem

Overview:
- Multi-cycle unified instruction/data memory. It is the responder end of the control unit's memory strobes (mr, mw) and the datapath address mux (iord selects PC or ALUOut upstream).
- Accepts one word read or write at a time and inserts a programmable number of wait states.
- Returns a one-cycle ready pulse, so the control unit can hold its fetch/load/store state until the access completes.
- Sits between the multicycle datapath and its IR/MDR registers.

Parameters:
- AW, 8, word-address width; the memory holds 2^AW 32-bit words.
- WAIT_CYC, 2, wait states per access, range 0..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- mr  in  1  read request from control unit
- mw  in  1  write request from control unit
- addr  in  32  byte address; word index is addr[AW+1:2]
- wdata  in  32  write data (register B)
- rdata  out  32  read data to IR/MDR
- ready  out  1  access complete, high for exactly one cycle
- busy  out  1  request accepted and not yet acknowledged
- err  out  1  request rejected, qualified by ready

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, rdata=0, ready=0, busy=0, err=0.
  - Latched address, data and op are cleared.
  - Memory array is not reset.
  - Reset during WAIT aborts the access; a pending write is never committed.
- States: IDLE, WAIT, ACK (registered, Moore outputs).
- IDLE:
  - Sample mr/mw on each edge.
  - Exactly one of mr or mw high: latch addr, wdata and op; set cnt=WAIT_CYC; go to WAIT.
  - mr and mw both high: go to ACK with err flag set; no access.
  - Neither high: stay in IDLE.
- WAIT:
  - busy=1.
  - cnt!=0: cnt decrements by 1 per edge.
  - cnt==0: go to ACK on the next edge and perform the access using the latched values.
    - Read: rdata <= mem[index].
    - Write: mem[index] <= wdata; rdata unchanged.
  - mr, mw, addr and wdata are ignored while in WAIT.
- ACK:
  - ready=1 and busy=0; err=1 only for a rejected request.
  - Always returns to IDLE on the next edge.
  - Requests present during ACK are ignored. The control unit drops or changes its strobe on the edge that ends ACK, so a held strobe is never double-counted.
- Latency:
  - Request seen in IDLE in cycle 0 gives ready in cycle WAIT_CYC+2.
  - Rejected request gives ready in cycle 1.
  - Back-to-back accesses therefore take WAIT_CYC+3 cycles each.
- rdata holds its value until the next successful read. Read data is valid while ready=1 and afterwards.
- Address wrap: bits above AW+1 are ignored; with AW=8, address 0x400 aliases 0x000.
- Write followed by read of the same address returns the new data; no bypass is needed because accesses are serialized.
- ready, busy and err are never high together with any state other than the one stated above.

Optional Feature:
- Macro: MCPU_MEM_ALIGN_CHK_EN.
- Defined:
  - A request in IDLE with addr[1:0]!=0 goes directly to ACK with err=1.
  - No memory access and no rdata change.
  - Checked together with the mr&mw conflict; either condition gives err.
- Undefined: addr[1:0] is ignored and misaligned addresses access the containing word.

Test Plan:
- Reset then read: hold rst=0 for 3 cycles, release; mr=1, addr=0x10 -> busy=1 for cycles 1..3, ready=1 in cycle 4 (WAIT_CYC=2), rdata = preloaded mem[4], err=0.
- Write then read: mw=1, addr=0x20, wdata=0xDEADBEEF until ready; then mr=1, addr=0x20 -> second ready shows rdata=0xDEADBEEF; rdata unchanged during the write.
- Conflict: mr=mw=1 in IDLE -> ready=1, err=1 in cycle 1; memory and rdata unchanged.
- Reset mid-write: mw=1, addr=0x30, wdata=0x12345678; assert rst in cycle 2 -> all outputs 0 immediately; later read of 0x30 returns the old value.
- WAIT_CYC=0 and wrap (AW=8): write 0xA5A5A5A5 to 0x004, read 0x404 -> ready every 2nd cycle after request, rdata=0xA5A5A5A5.
- MCPU_MEM_ALIGN_CHK_EN: mr=1, addr=0x13 -> defined: ready and err in cycle 1, rdata unchanged; undefined: normal read of mem[4], err=0.
